cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 6 +
 rtl/result_fifo.sv | 37 +++
 rtl/cdb_arbiter.sv | 85 ++++++++
 tb/tb_cdb_arbiter.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg: tag/data widths and the "no dependency" tag shared with the reservation station
package cdb_arbiter_pkg;
  localparam int CDB_LABEL_W = 4;
  localparam int CDB_DATA_W = 32;
  localparam int NO_DEP_LABEL = 0;
endpackage

// File: rtl/result_fifo.sv
// result_fifo: single-source DEPTH-entry result buffer; guards itself against overflow and underflow
module result_fifo #(
  parameter int DEPTH = 2,
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic         not_full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic wr_en, rd_en;
  assign not_full_o = cnt_q != (AW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
  assign wr_en = push_i & not_full_o;
  assign rd_en = pop_i & ~empty_o;
  assign head_o = mem_q[rd_q];
  always_ff @(posedge clk)
    if (wr_en) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers per-source results and broadcasts one per cycle on the common data bus,
// round-robin across sources, with registered broadcast outputs
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 3,
  parameter int DEPTH = 2,
  parameter int LABEL_W = CDB_LABEL_W,
  parameter int DATA_W = CDB_DATA_W
) (
  input  logic                       clk,
  input  logic                       RST,
  input  logic [NUM_SRC-1:0]         srcValid,
  input  logic [NUM_SRC*LABEL_W-1:0] srcLabel,
  input  logic [NUM_SRC*DATA_W-1:0]  srcData,
  output logic [NUM_SRC-1:0]         srcReady,
  output logic                       BCEN,
  output logic [LABEL_W-1:0]         BClabel,
  output logic [DATA_W-1:0]          BCdata,
  output logic                       errLabel
);
  localparam int PW = NUM_SRC > 1 ? $clog2(NUM_SRC) : 1;
  localparam int EW = LABEL_W + DATA_W;
  logic [NUM_SRC-1:0] empty_w, push_w, pop_w, bad_w;
  logic [EW-1:0] head_w [NUM_SRC];
  logic gnt_vld;
  logic [PW-1:0] gnt_idx, rr_q, rr_d;
  logic bcen_q, bcen_d, err_q, err_d;
  logic [LABEL_W-1:0] bclabel_q, bclabel_d;
  logic [DATA_W-1:0] bcdata_q, bcdata_d;
  for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
    logic [LABEL_W-1:0] lab;
    logic offered;
    assign lab = srcLabel[i*LABEL_W +: LABEL_W];
    assign offered = srcValid[i] & srcReady[i];
    assign push_w[i] = offered & (lab != LABEL_W'(NO_DEP_LABEL));
    assign bad_w[i] = offered & (lab == LABEL_W'(NO_DEP_LABEL));
    assign pop_w[i] = gnt_vld & (gnt_idx == PW'(i));
    result_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
      .clk       (clk),
      .rst       (RST),
      .push_i    (push_w[i]),
      .din_i     ({lab, srcData[i*DATA_W +: DATA_W]}),
      .pop_i     (pop_w[i]),
      .not_full_o(srcReady[i]),
      .empty_o   (empty_w[i]),
      .head_o    (head_w[i])
    );
  end
  // Scan from the highest offset down so the lowest offset from rr_q wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--)
      if (!empty_w[(int'(rr_q) + k) % NUM_SRC]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'((int'(rr_q) + k) % NUM_SRC);
      end
  end
  always_comb begin
    rr_d = gnt_vld ? (gnt_idx == PW'(NUM_SRC - 1) ? '0 : gnt_idx + 1'b1) : rr_q;
    bcen_d = gnt_vld;
    bclabel_d = gnt_vld ? head_w[gnt_idx][EW-1:DATA_W] : bclabel_q;
    bcdata_d = gnt_vld ? head_w[gnt_idx][DATA_W-1:0] : bcdata_q;
    err_d = err_q | (|bad_w);
  end
  always_ff @(posedge clk or posedge RST)
    if (RST) begin
      rr_q <= '0;
      bcen_q <= 1'b0;
      bclabel_q <= '0;
      bcdata_q <= '0;
      err_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      bcen_q <= bcen_d;
      bclabel_q <= bclabel_d;
      bcdata_q <= bcdata_d;
      err_q <= err_d;
    end
  assign BCEN = bcen_q;
  assign BClabel = bclabel_q;
  assign BCdata = bcdata_q;
  assign errLabel = err_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed scenarios for the CDB arbiter with hand-computed broadcast expectations
module tb_cdb_arbiter;
  logic clk = 1'b0;
  logic RST;
  logic [2:0] srcValid;
  logic [11:0] srcLabel;
  logic [95:0] srcData;
  logic [2:0] srcReady;
  logic BCEN;
  logic [3:0] BClabel;
  logic [31:0] BCdata;
  logic errLabel;
  int errors = 0;
  int checks = 0;
  cdb_arbiter dut (
    .clk(clk), .RST(RST), .srcValid(srcValid), .srcLabel(srcLabel), .srcData(srcData),
    .srcReady(srcReady), .BCEN(BCEN), .BClabel(BClabel), .BCdata(BCdata), .errLabel(errLabel)
  );
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic offer(int i, logic [3:0] l, logic [31:0] d);
    srcValid[i] = 1'b1;
    srcLabel[i*4 +: 4] = l;
    srcData[i*32 +: 32] = d;
  endtask
  task automatic idle();
    srcValid = '0;
  endtask
  task automatic bc(string tag, logic [3:0] l, logic [31:0] d);
    chk({tag, ".en"}, BCEN, 1);
    chk({tag, ".label"}, BClabel, l);
    chk({tag, ".data"}, BCdata, d);
  endtask
  task automatic rst_pulse();
    #1 RST = 1'b1;
    #1 RST = 1'b0;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    RST = 1'b1;
    srcValid = '0;
    srcLabel = '0;
    srcData = '0;
    #1;
    chk("rst.en", BCEN, 0);
    chk("rst.label", BClabel, 0);
    chk("rst.data", BCdata, 0);
    chk("rst.err", errLabel, 0);
    chk("rst.ready", srcReady, 3'b111);
    #1 RST = 1'b0;
    // single source latency
    offer(0, 4'd5, 32'h1234);
    tick();
    idle();
    chk("single.nobypass", BCEN, 0);
    chk("single.ready", srcReady, 3'b111);
    tick();
    bc("single.bc", 4'd5, 32'h1234);
    tick();
    chk("single.off", BCEN, 0);
    chk("single.hold", BClabel, 5);
    // contention across all three sources
    rst_pulse();
    offer(0, 4'd1, 32'hA1);
    offer(1, 4'd2, 32'hA2);
    offer(2, 4'd3, 32'hA3);
    tick();
    idle();
    chk("cont.nobypass", BCEN, 0);
    tick();
    bc("cont.first", 4'd1, 32'hA1);
    tick();
    bc("cont.second", 4'd2, 32'hA2);
    tick();
    bc("cont.third", 4'd3, 32'hA3);
    tick();
    chk("cont.off", BCEN, 0);
    offer(0, 4'd6, 32'hB0);
    offer(2, 4'd7, 32'hB2);
    tick();
    idle();
    tick();
    bc("cont.rr0", 4'd6, 32'hB0);
    tick();
    bc("cont.rr2", 4'd7, 32'hB2);
    // back-pressure on source 1
    rst_pulse();
    offer(0, 4'd8, 32'hC0);
    offer(1, 4'd9, 32'hCA);
    tick();
    chk("bp.nobypass", BCEN, 0);
    offer(0, 4'd10, 32'hC1);
    offer(1, 4'd11, 32'hCB);
    tick();
    bc("bp.x1", 4'd8, 32'hC0);
    chk("bp.full", srcReady, 3'b101);
    srcValid[0] = 1'b0;
    offer(1, 4'd12, 32'hCC);
    tick();
    bc("bp.a", 4'd9, 32'hCA);
    chk("bp.ready", srcReady, 3'b111);
    tick();
    idle();
    bc("bp.x2", 4'd10, 32'hC1);
    chk("bp.full2", srcReady, 3'b101);
    tick();
    bc("bp.b", 4'd11, 32'hCB);
    tick();
    bc("bp.c", 4'd12, 32'hCC);
    tick();
    chk("bp.off", BCEN, 0);
    // label 0 is dropped and flagged
    rst_pulse();
    offer(2, 4'd0, 32'hDEAD);
    tick();
    idle();
    chk("lab0.err", errLabel, 1);
    chk("lab0.en", BCEN, 0);
    tick();
    chk("lab0.sticky", errLabel, 1);
    chk("lab0.nobc", BCEN, 0);
    chk("lab0.ready", srcReady, 3'b111);
    rst_pulse();
    chk("lab0.clr", errLabel, 0);
    // reset mid-flight discards buffered entries
    offer(0, 4'd3, 32'hE0);
    offer(1, 4'd4, 32'hE1);
    tick();
    idle();
    tick();
    bc("mid.bc", 4'd3, 32'hE0);
    #1 RST = 1'b1;
    #1;
    chk("mid.en", BCEN, 0);
    chk("mid.label", BClabel, 0);
    chk("mid.data", BCdata, 0);
    chk("mid.ready", srcReady, 3'b111);
    RST = 1'b0;
    tick();
    chk("mid.drop1", BCEN, 0);
    tick();
    chk("mid.drop2", BCEN, 0);
    // simultaneous push and pop at occupancy 1
    offer(0, 4'd6, 32'hF1);
    tick();
    offer(0, 4'd7, 32'hF2);
    tick();
    idle();
    bc("pp.old", 4'd6, 32'hF1);
    chk("pp.ready", srcReady, 3'b111);
    tick();
    bc("pp.new", 4'd7, 32'hF2);
    tick();
    chk("pp.off", BCEN, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
